// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared operation encodings, FSM state encoding and flag bundle
//            for the iterative ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operation select encoding; 11..15 are illegal.
  localparam logic [3:0] C_OP_ADD  = 4'd0;
  localparam logic [3:0] C_OP_SUB  = 4'd1;
  localparam logic [3:0] C_OP_NOT  = 4'd2;
  localparam logic [3:0] C_OP_AND  = 4'd3;
  localparam logic [3:0] C_OP_OR   = 4'd4;
  localparam logic [3:0] C_OP_XOR  = 4'd5;
  localparam logic [3:0] C_OP_SLT  = 4'd6;
  localparam logic [3:0] C_OP_EQ   = 4'd7;
  localparam logic [3:0] C_OP_MUL  = 4'd8;
  localparam logic [3:0] C_OP_DIVU = 4'd9;
  localparam logic [3:0] C_OP_REMU = 4'd10;

  // Control FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Status flags presented alongside the result.
  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
    logic cmp;
    logic err;
  } flags_t;

  // True for operations that run on the multi-cycle shift/add datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == C_OP_MUL) || (op == C_OP_DIVU) || (op == C_OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_if
// Brief    : Operand/result handshake bundle for the iterative ALU.
//            master = producer/consumer side, slave = the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_iter_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             cmp;
  logic             err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry, cmp, err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry, cmp, err
  );

endinterface
`default_nettype wire

// File: rtl/alu_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_core
// Brief    : Multi-cycle unsigned multiply (shift-add) and divide/remainder
//            (restoring shift-subtract). Runs exactly WIDTH iterations after
//            a start pulse; final values stay in the registers afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [3:0]       start_op,
  input  wire logic [WIDTH-1:0] start_a,
  input  wire logic [WIDTH-1:0] start_b,
  output logic                  last,
  output logic [WIDTH-1:0]      result,
  output logic                  hi_nonzero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // acc: product high half (MUL) or partial remainder (DIV/REM).
  // sr : multiplier shifting out / product low half (MUL), or dividend
  //      shifting out with quotient bits shifting in (DIV/REM).
  // opnd: multiplicand (MUL) or divisor (DIV/REM).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             mul_q, mul_d;
  logic             rem_q, rem_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_borrow;

  // Per-iteration arithmetic for both algorithms.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {acc_q, sr_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    // The partial remainder is always below the divisor (or below 2^WIDTH
    // for a zero divisor), so bit WIDTH of the difference is set exactly
    // when the trial subtraction goes negative.
    rem_borrow = rem_diff[WIDTH];
    last       = busy_q && (cnt_q == LAST_CNT);
  end

  // Next-state: load on start, otherwise iterate while busy.
  always_comb begin
    acc_d  = acc_q;
    sr_d   = sr_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    mul_d  = mul_q;
    rem_d  = rem_q;
    if (start) begin
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      mul_d  = (start_op == C_OP_MUL);
      rem_d  = (start_op == C_OP_REMU);
      if (start_op == C_OP_MUL) begin
        sr_d   = start_b;
        opnd_d = start_a;
      end else begin
        sr_d   = start_a;
        opnd_d = start_b;
      end
    end else if (busy_q) begin
      if (mul_q) begin
        acc_d = mul_sum[WIDTH:1];
        sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
      end else if (!rem_borrow) begin
        acc_d = rem_diff[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      mul_q  <= mul_d;
      rem_q  <= rem_d;
    end
  end

  // A zero divisor naturally yields quotient all-ones and remainder = a.
  always_comb begin
    result     = rem_q ? acc_q : sr_q;
    hi_nonzero = mul_q && (|acc_q);
  end

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter
// Brief    : Handshaked ALU. Single-cycle ops (add/sub/logic/compare) are
//            evaluated at accept; MUL/DIVU/REMU run WIDTH iterations on
//            alu_iter_core. Result held until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_iter_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             iter_q, iter_d;

  logic             sub_mode;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] comb_result;
  flags_t           comb_flags;

  logic             core_start;
  logic             core_last;
  logic [WIDTH-1:0] core_result;
  logic             core_hi_nonzero;

  // Shared adder/subtractor: ADD adds, SUB/SLT/EQ add the inverted operand.
  // SLT and EQ always compare a against b with no borrow-in.
  always_comb begin
    sub_mode = (bus.op == C_OP_SUB) || (bus.op == C_OP_SLT) || (bus.op == C_OP_EQ);
    b_eff    = sub_mode ? ~bus.b : bus.b;
    if (bus.op == C_OP_ADD) begin
      cin_eff = bus.cin;
    end else if (bus.op == C_OP_SUB) begin
      cin_eff = ~bus.cin;
    end else begin
      cin_eff = 1'b1;
    end
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    add_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  end

  // Single-cycle operation results and flags, taken straight from the bus.
  always_comb begin
    comb_result = '0;
    comb_flags  = '0;
    case (bus.op)
      C_OP_ADD: begin
        comb_result         = sum[WIDTH-1:0];
        comb_flags.carry    = sum[WIDTH];
        comb_flags.overflow = add_ovf;
      end
      C_OP_SUB: begin
        comb_result         = sum[WIDTH-1:0];
        comb_flags.carry    = ~sum[WIDTH];
        comb_flags.overflow = add_ovf;
      end
      C_OP_NOT: comb_result = ~bus.a;
      C_OP_AND: comb_result = bus.a & bus.b;
      C_OP_OR:  comb_result = bus.a | bus.b;
      C_OP_XOR: comb_result = bus.a ^ bus.b;
      C_OP_SLT: begin
        comb_flags.cmp = sum[WIDTH-1] ^ add_ovf;
        comb_result    = {{(WIDTH-1){1'b0}}, comb_flags.cmp};
      end
      C_OP_EQ: begin
        comb_flags.cmp = ~|sum[WIDTH-1:0];
        comb_result    = {{(WIDTH-1){1'b0}}, comb_flags.cmp};
      end
      C_OP_MUL, C_OP_DIVU, C_OP_REMU: comb_result = '0;
      default: comb_flags.err = 1'b1;
    endcase
    comb_flags.zero = ~|comb_result;
  end

  // Control FSM next-state and capture of single-cycle results.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    iter_d     = iter_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_iter_op(bus.op)) begin
            core_start = 1'b1;
            iter_d     = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            result_d = comb_result;
            flags_d  = comb_flags;
            iter_d   = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (core_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and held single-cycle result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      iter_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      iter_q   <= iter_d;
    end
  end

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start      (core_start),
    .start_op   (bus.op),
    .start_a    (bus.a),
    .start_b    (bus.b),
    .last       (core_last),
    .result     (core_result),
    .hi_nonzero (core_hi_nonzero)
  );

  // Output mux: iterative results come from the core, which stops updating
  // once its iterations finish, so they stay stable while held in DONE.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    if (iter_q) begin
      bus.result   = core_result;
      bus.zero     = ~|core_result;
      bus.carry    = core_hi_nonzero;
      bus.overflow = 1'b0;
      bus.cmp      = 1'b0;
      bus.err      = 1'b0;
    end else begin
      bus.result   = result_q;
      bus.zero     = flags_q.zero;
      bus.carry    = flags_q.carry;
      bus.overflow = flags_q.overflow;
      bus.cmp      = flags_q.cmp;
      bus.err      = flags_q.err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter
// Brief    : Self-checking bench for alu_iter (WIDTH=8): directed cases,
//            randomized ops against an arithmetic reference model,
//            backpressure, reset mid-operation and back-to-back accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carry;
    logic         cmp;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t   e;
    longint full, half, ua, ub, sa, sb, c, r, t;
    full = longint'(1) << W;
    half = full / 2;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    c  = cin ? 1 : 0;
    e.overflow = 1'b0; e.carry = 1'b0; e.cmp = 1'b0; e.err = 1'b0;
    r = 0;
    case (op)
      4'd0: begin
        r = ua + ub + c; e.carry = (r >= full); r = r % full;
        t = sa + sb + c; e.overflow = (t > half - 1) || (t < -half);
      end
      4'd1: begin
        r = ua - ub - c; e.carry = (ua < ub + c); if (r < 0) r = r + full;
        t = sa - sb - c; e.overflow = (t > half - 1) || (t < -half);
      end
      4'd2: r = full - 1 - ua;
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: begin e.cmp = (sa < sb); r = e.cmp ? 1 : 0; end
      4'd7: begin e.cmp = (ua == ub); r = e.cmp ? 1 : 0; end
      4'd8: begin r = ua * ub; e.carry = ((r / full) != 0); r = r % full; end
      4'd9: r = (ub == 0) ? full - 1 : ua / ub;
      4'd10: r = (ub == 0) ? ua : ua % ub;
      default: begin e.err = 1'b1; r = 0; end
    endcase
    e.result = r[W-1:0];
    e.zero   = (r == 0);
    return e;
  endfunction

  function automatic logic [W+4:0] pack(input exp_t e);
    return {e.result, e.zero, e.overflow, e.carry, e.cmp, e.err};
  endfunction

  // Flags that are defined for each op; carry/overflow are not defined for
  // SLT/EQ and cmp is not defined for arithmetic ops.
  function automatic logic [W+4:0] care(input logic [3:0] op);
    logic [W+4:0] m;
    m = '1;
    if (op == 4'd6 || op == 4'd7) m[3:2] = 2'b00;
    if (op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9 || op == 4'd10) m[1] = 1'b0;
    return m;
  endfunction

  function automatic exp_t sample();
    exp_t o;
    o.result = bus.result; o.zero = bus.zero; o.overflow = bus.overflow;
    o.carry = bus.carry; o.cmp = bus.cmp; o.err = bus.err;
    return o;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = '1;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Drive one bundle, wait (bounded) for the result, sample it, handshake.
  // lat = cycles from the accept edge until out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output exp_t o, output int lat, output bit valid);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 4 * W) begin
      @(posedge clk); #1; lat++;
    end
    valid = bus.out_valid;
    o = sample();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (pack(sample()) !== '0) begin
      errors++;
      $display("FAIL reset_outputs: {result,flags}=%h, expected 0", pack(sample()));
    end
  endtask

  task automatic test_arith();
    exp_t o; int lat; bit v;
    run_op(4'd0, 8'h7F, 8'h01, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h80 || o.overflow !== 1'b1 || o.carry !== 1'b0 || o.zero !== 1'b0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL add_7f_01: valid=%b res=%h ovf=%b c=%b z=%b err=%b, expected 80 1 0 0 0", v, o.result, o.overflow, o.carry, o.zero, o.err);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_latency: %0d cycles, expected 1", lat); end
    run_op(4'd1, 8'h03, 8'h05, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'hFE || o.carry !== 1'b1 || o.overflow !== 1'b0 || o.zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_03_05: res=%h c=%b ovf=%b z=%b, expected FE 1 0 0", o.result, o.carry, o.overflow, o.zero);
    end
    run_op(4'd6, 8'h03, 8'h05, 1'b0, o, lat, v);
    checks++;
    if (!v || o.cmp !== 1'b1 || o.result !== 8'h01 || o.zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_03_05: res=%h cmp=%b z=%b, expected 01 1 0", o.result, o.cmp, o.zero);
    end
    run_op(4'd7, 8'h5A, 8'h5A, 1'b0, o, lat, v);
    checks++;
    if (!v || o.cmp !== 1'b1 || o.result !== 8'h01 || o.zero !== 1'b0) begin
      errors++;
      $display("FAIL eq_5a_5a: res=%h cmp=%b z=%b, expected 01 1 0", o.result, o.cmp, o.zero);
    end
    run_op(4'd12, 8'h12, 8'h34, 1'b1, o, lat, v);
    checks++;
    if (!v || o.err !== 1'b1 || o.result !== 8'h00 || o.zero !== 1'b1 || o.carry !== 1'b0 || o.overflow !== 1'b0 || o.cmp !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op12: err=%b res=%h z=%b c=%b ovf=%b cmp=%b, expected 1 00 1 0 0 0", o.err, o.result, o.zero, o.carry, o.overflow, o.cmp);
    end
  endtask

  task automatic test_mul_div();
    exp_t o; int lat; bit v;
    run_op(4'd8, 8'h10, 8'h11, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h10 || o.carry !== 1'b1 || o.overflow !== 1'b0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL mul_10_11: res=%h c=%b ovf=%b err=%b, expected 10 1 0 0", o.result, o.carry, o.overflow, o.err);
    end
    checks++;
    if (lat !== W + 1) begin errors++; $display("FAIL mul_latency: %0d cycles, expected %0d", lat, W + 1); end
    run_op(4'd9, 8'h64, 8'h07, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h0E || o.carry !== 1'b0 || o.overflow !== 1'b0 || lat !== W + 1) begin
      errors++;
      $display("FAIL divu_64_07: res=%h c=%b ovf=%b lat=%0d, expected 0E 0 0 %0d", o.result, o.carry, o.overflow, lat, W + 1);
    end
    run_op(4'd10, 8'h64, 8'h07, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h02) begin errors++; $display("FAIL remu_64_07: res=%h, expected 02", o.result); end
    run_op(4'd9, 8'h64, 8'h00, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'hFF || o.carry !== 1'b0 || o.overflow !== 1'b0 || lat !== W + 1) begin
      errors++;
      $display("FAIL divu_by_zero: res=%h c=%b ovf=%b lat=%0d, expected FF 0 0 %0d", o.result, o.carry, o.overflow, lat, W + 1);
    end
    run_op(4'd10, 8'h64, 8'h00, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h64 || o.zero !== 1'b0 || lat !== W + 1) begin
      errors++;
      $display("FAIL remu_by_zero: res=%h z=%b lat=%0d, expected 64 0 %0d", o.result, o.zero, lat, W + 1);
    end
  endtask

  task automatic test_random();
    exp_t o, e; int lat, exp_lat; bit v;
    logic [3:0] op; logic [W-1:0] a, b; logic cin;
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = pick_operand();
      b   = pick_operand();
      cin = 1'($urandom_range(0, 1));
      e   = model(op, a, b, cin);
      run_op(op, a, b, cin, o, lat, v);
      checks++;
      if (!v || (pack(o) & care(op)) !== (pack(e) & care(op))) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h cin=%b: valid=%b got %h, expected %h (care %h)", i, op, a, b, cin, v, pack(o), pack(e), care(op));
      end
      exp_lat = (op == 4'd8 || op == 4'd9 || op == 4'd10) ? W + 1 : 1;
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL random_latency[%0d] op=%0d: %0d cycles, expected %0d", i, op, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t snap, now; int lat; bit held_ok;
    bus.in_valid = 1'b1; bus.op = 4'd8; bus.a = 8'h10; bus.b = 8'h11; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 4 * W) begin @(posedge clk); #1; lat++; end
    snap = sample();
    checks++;
    if (bus.out_valid !== 1'b1 || snap.result !== 8'h10 || snap.carry !== 1'b1) begin
      errors++;
      $display("FAIL bp_result: valid=%b res=%h c=%b, expected 1 10 1", bus.out_valid, snap.result, snap.carry);
    end
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      now = sample();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || pack(now) !== pack(snap)) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL bp_hold: valid=%b in_ready=%b out=%h, expected 1 0 %h", bus.out_valid, bus.in_ready, pack(now), pack(snap));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen; exp_t o; int lat; bit v;
    bus.in_valid = 1'b1; bus.op = 4'd8; bus.a = 8'hC3; bus.b = 8'h5D; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || pack(sample()) !== '0) begin
      errors++;
      $display("FAIL rst_mid_mul: in_ready=%b out_valid=%b out=%h, expected 1 0 0", bus.in_ready, bus.out_valid, pack(sample()));
    end
    seen = 1'b0;
    for (int c = 0; c < 2 * W + 4; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_discard: out_valid=1 seen after reset, expected 0"); end
    run_op(4'd0, 8'h01, 8'h01, 1'b0, o, lat, v);
    checks++;
    if (!v || o.result !== 8'h02) begin errors++; $display("FAIL rst_recover: res=%h valid=%b, expected 02 1", o.result, v); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    int acc_c[$];
    exp_t e, o;
    logic [3:0] op; logic [W-1:0] a, b; logic cin; bit acc_now;
    op = 4'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); cin = 1'($urandom_range(0, 1));
    bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: out_valid with nothing pending at cycle %0d", c);
        end else begin
          e = q.pop_front(); o = sample();
          if ((pack(o) & care(4'd2)) !== (pack(e) & care(4'd2)) && (pack(o) & care(4'd6)) !== (pack(e) & care(4'd6))) begin
            errors++; $display("FAIL b2b_result cycle %0d: got %h, expected %h", c, pack(o), pack(e));
          end
        end
      end
      acc_now = bus.in_ready;
      if (acc_now) begin q.push_back(model(op, a, b, cin)); acc_c.push_back(c); end
      @(posedge clk); #1;
      if (acc_now) begin
        op = 4'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); cin = 1'($urandom_range(0, 1));
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
      end
    end
    bus.in_valid = 1'b0;
    if (bus.out_valid && q.size() != 0) begin
      checks++;
      e = q.pop_front(); o = sample();
      if ((pack(o) & care(4'd2)) !== (pack(e) & care(4'd2)) && (pack(o) & care(4'd6)) !== (pack(e) & care(4'd6))) begin
        errors++; $display("FAIL b2b_last: got %h, expected %h", pack(o), pack(e));
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (q.size() != 0 || acc_c.size() < 15) begin
      errors++; $display("FAIL b2b_count: pending=%0d accepts=%0d, expected 0 and >=15", q.size(), acc_c.size());
    end
    for (int i = 1; i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] - acc_c[i-1] != 2) begin
        errors++; $display("FAIL b2b_spacing[%0d]: %0d cycles, expected 2", i, acc_c[i] - acc_c[i-1]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_mul_div();
    test_random();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
